// File: rtl/hazard_pkg.sv
// Shared types for the rv32 hazard/forwarding controller: FSM states,
// operand-source select codes and branch funct3 codes.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_ACC = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/hazard_fwd_ctl_br_cond.sv
// Branch condition evaluator: decodes funct3 and compares two XLEN operands.
// Reserved codes (010/011) evaluate false.
module br_cond
    import hazard_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (a == b);
            F3_BNE:  cond = (a != b);
            F3_BLT:  cond = ($signed(a) <  $signed(b));
            F3_BGE:  cond = ($signed(a) >= $signed(b));
            F3_BLTU: cond = (a <  b);
            F3_BGEU: cond = (a >= b);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/hazard_fwd_ctl.sv
// Hazard/forwarding controller: same-cycle operand forwarding, load-use stall,
// branch redirect with multi-cycle flush. Optional HAZARD_PERF_CNT_EN adds counters.
module hazard_fwd_ctl
    import hazard_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] de_rs1,
    input  logic [REG_AW-1:0] de_rs2,
    input  logic              de_rs1_used,
    input  logic              de_rs2_used,
    input  logic [XLEN-1:0]   de_data_a,
    input  logic [XLEN-1:0]   de_data_b,
    input  logic [REG_AW-1:0] exe_rd,
    input  logic [REG_AW-1:0] acc_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              exe_we,
    input  logic              acc_we,
    input  logic              wb_we,
    input  logic              exe_is_load,
    input  logic              acc_is_load,
    input  logic [XLEN-1:0]   exe_result,
    input  logic [XLEN-1:0]   acc_alu,
    input  logic [XLEN-1:0]   acc_dmem,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              exe_is_branch,
    input  logic              exe_is_jump,
    input  logic [2:0]        exe_funct3,
    input  logic [XLEN-1:0]   exe_op_a,
    input  logic [XLEN-1:0]   exe_op_b,
    input  logic [XLEN-1:0]   exe_target,
    output logic [XLEN-1:0]   fwd_a,
    output logic [XLEN-1:0]   fwd_b,
    output logic [1:0]        fwd_sel_a,
    output logic [1:0]        fwd_sel_b,
    output logic              stall,
    output logic              flush,
    output logic              pc_sel,
    output logic [XLEN-1:0]   pc_target,
    output logic [1:0]        dbg_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
    localparam logic [2:0] LD_RELOAD    = 3'(LOAD_LAT - 1);

    // Highest-priority younger producer wins; a load still in exe cannot forward.
    function automatic logic [XLEN+1:0] pick_src(
        input logic              used,
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   rf_val
    );
        logic live;
        live = used && (rs != '0);
        if (live && exe_we && (exe_rd == rs) && !exe_is_load)
            return {FWD_EXE, exe_result};
        else if (live && acc_we && (acc_rd == rs))
            return {FWD_ACC, acc_is_load ? acc_dmem : acc_alu};
        else if (live && wb_we && (wb_rd == rs))
            return {FWD_WB, wb_data};
        else
            return {FWD_RF, rf_val};
    endfunction

    always_comb {fwd_sel_a, fwd_a} = pick_src(de_rs1_used, de_rs1, de_data_a);
    always_comb {fwd_sel_b, fwd_b} = pick_src(de_rs2_used, de_rs2, de_data_b);

    logic lu_a, lu_b, load_use, br_true, taken;

    assign lu_a     = de_rs1_used && (de_rs1 != '0) && exe_we && (exe_rd == de_rs1);
    assign lu_b     = de_rs2_used && (de_rs2 != '0) && exe_we && (exe_rd == de_rs2);
    assign load_use = exe_is_load && (lu_a || lu_b);

    br_cond #(.XLEN(XLEN)) u_br_cond (
        .funct3 (exe_funct3),
        .a      (exe_op_a),
        .b      (exe_op_b),
        .cond   (br_true)
    );

    assign taken = exe_is_jump || (exe_is_branch && br_true);

    hz_state_t       state, state_n;
    logic [2:0]      cnt, cnt_n;
    logic            raw_stall, raw_flush, raw_pc_sel;
    logic [XLEN-1:0] raw_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        raw_stall  = 1'b0;
        raw_flush  = 1'b0;
        raw_pc_sel = 1'b0;
        raw_target = '0;
        case (state)
            FLUSH: begin
                raw_flush = 1'b1;
                if (cnt <= 3'd1) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 3'd1;
                end
            end
            default: begin
                // RUN and LD_STALL: a taken control transfer always wins over stalling.
                if (taken) begin
                    raw_pc_sel = 1'b1;
                    raw_target = exe_target;
                    raw_flush  = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_n = FLUSH;
                        cnt_n   = FLUSH_RELOAD;
                    end else begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end
                end else if (state == LD_STALL) begin
                    raw_stall = 1'b1;
                    if (cnt <= 3'd1) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - 3'd1;
                    end
                end else if (load_use) begin
                    raw_stall = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_n = LD_STALL;
                        cnt_n   = LD_RELOAD;
                    end
                end
            end
        endcase
    end

    // Control outputs are forced quiet while reset is held, whatever the state.
    assign stall     = raw_stall  && !rst;
    assign flush     = raw_flush  && !rst;
    assign pc_sel    = raw_pc_sel && !rst;
    assign pc_target = rst ? '0 : raw_target;
    assign dbg_state = state;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_ctl.sv
// Bench for hazard_fwd_ctl: forwarding vector table, directed stall/flush/reset
// sequences, and randomized cycles against a cycle-count reference model.
module tb_hazard_fwd_ctl;
  import hazard_pkg::*;

  localparam int LL  = 2;
  localparam int FD  = 2;
  localparam int FD4 = 4;
  localparam logic [31:0] DA = 32'hAAAA0001;
  localparam logic [31:0] DB = 32'hBBBB0002;
  localparam logic [31:0] EX = 32'h00000011;
  localparam logic [31:0] AL = 32'h00000022;
  localparam logic [31:0] DM = 32'h0000ABCD;
  localparam logic [31:0] WB = 32'h00000033;
  localparam int W = 103;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]  de_rs1, de_rs2, exe_rd, acc_rd, wb_rd;
  logic        de_rs1_used, de_rs2_used, exe_we, acc_we, wb_we;
  logic        exe_is_load, acc_is_load, exe_is_branch, exe_is_jump;
  logic [31:0] de_data_a, de_data_b, exe_result, acc_alu, acc_dmem, wb_data;
  logic [2:0]  exe_funct3;
  logic [31:0] exe_op_a, exe_op_b, exe_target;

  logic [31:0] fwd_a, fwd_b, pc_target, fwd_a4, fwd_b4, pc_target4;
  logic [1:0]  fwd_sel_a, fwd_sel_b, fwd_sel_a4, fwd_sel_b4, dbg_state, dbg_state4;
  logic        stall, flush, pc_sel, stall4, flush4, pc_sel4;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_stall_cnt4, perf_flush_cnt4;
`endif

  hazard_fwd_ctl #(.XLEN(32), .REG_AW(5), .LOAD_LAT(LL), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .de_data_a(de_data_a), .de_data_b(de_data_b),
    .exe_rd(exe_rd), .acc_rd(acc_rd), .wb_rd(wb_rd),
    .exe_we(exe_we), .acc_we(acc_we), .wb_we(wb_we),
    .exe_is_load(exe_is_load), .acc_is_load(acc_is_load),
    .exe_result(exe_result), .acc_alu(acc_alu), .acc_dmem(acc_dmem), .wb_data(wb_data),
    .exe_is_branch(exe_is_branch), .exe_is_jump(exe_is_jump), .exe_funct3(exe_funct3),
    .exe_op_a(exe_op_a), .exe_op_b(exe_op_b), .exe_target(exe_target),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall(stall), .flush(flush), .pc_sel(pc_sel), .pc_target(pc_target),
    .dbg_state(dbg_state)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  hazard_fwd_ctl #(.XLEN(32), .REG_AW(5), .LOAD_LAT(1), .FLUSH_DEPTH(FD4)) dut4 (
    .clk(clk), .rst(rst),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .de_data_a(de_data_a), .de_data_b(de_data_b),
    .exe_rd(exe_rd), .acc_rd(acc_rd), .wb_rd(wb_rd),
    .exe_we(exe_we), .acc_we(acc_we), .wb_we(wb_we),
    .exe_is_load(exe_is_load), .acc_is_load(acc_is_load),
    .exe_result(exe_result), .acc_alu(acc_alu), .acc_dmem(acc_dmem), .wb_data(wb_data),
    .exe_is_branch(exe_is_branch), .exe_is_jump(exe_is_jump), .exe_funct3(exe_funct3),
    .exe_op_a(exe_op_a), .exe_op_b(exe_op_b), .exe_target(exe_target),
    .fwd_a(fwd_a4), .fwd_b(fwd_b4), .fwd_sel_a(fwd_sel_a4), .fwd_sel_b(fwd_sel_b4),
    .stall(stall4), .flush(flush4), .pc_sel(pc_sel4), .pc_target(pc_target4),
    .dbg_state(dbg_state4)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt4), .perf_flush_cnt(perf_flush_cnt4)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    de_rs1 = '0; de_rs2 = '0; de_rs1_used = 1'b0; de_rs2_used = 1'b0;
    de_data_a = DA; de_data_b = DB;
    exe_rd = '0; acc_rd = '0; wb_rd = '0;
    exe_we = 1'b0; acc_we = 1'b0; wb_we = 1'b0;
    exe_is_load = 1'b0; acc_is_load = 1'b0;
    exe_result = EX; acc_alu = AL; acc_dmem = DM; wb_data = WB;
    exe_is_branch = 1'b0; exe_is_jump = 1'b0; exe_funct3 = 3'b000;
    exe_op_a = '0; exe_op_b = '0; exe_target = '0;
  endtask

  function automatic logic [34:0] ctl();
    return {stall, flush, pc_sel, pc_target};
  endfunction

  function automatic logic [34:0] ctl4();
    return {stall4, flush4, pc_sel4, pc_target4};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [33:0] ref_fwd(input logic used, input logic [4:0] rs, input logic [31:0] rf);
    logic [4:0]  rd_l[3];
    logic        we_l[3];
    logic [31:0] v_l[3];
    rd_l[0] = exe_rd; rd_l[1] = acc_rd; rd_l[2] = wb_rd;
    we_l[0] = exe_we; we_l[1] = acc_we; we_l[2] = wb_we;
    v_l[0] = exe_result; v_l[1] = acc_is_load ? acc_dmem : acc_alu; v_l[2] = wb_data;
    if (!used || rs == 5'd0) return {2'd0, rf};
    for (int i = 0; i < 3; i++) begin
      if (we_l[i] && rd_l[i] == rs) begin
        if (i == 0 && exe_is_load) continue;
        return {2'(i + 1), v_l[i]};
      end
    end
    return {2'd0, rf};
  endfunction

  function automatic logic ref_taken();
    if (exe_is_jump) return 1'b1;
    if (!exe_is_branch) return 1'b0;
    case (exe_funct3)
      3'b000: return exe_op_a == exe_op_b;
      3'b001: return exe_op_a != exe_op_b;
      3'b100: return $signed(exe_op_a) <  $signed(exe_op_b);
      3'b101: return $signed(exe_op_a) >= $signed(exe_op_b);
      3'b110: return exe_op_a <  exe_op_b;
      3'b111: return exe_op_a >= exe_op_b;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- forwarding vector table ----------------
  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] erd, ard, wrd;
    logic       ewe, awe, ald, wwe;
    logic [1:0] sa;
    logic [31:0] a;
    logic [1:0] sb;
    logic [31:0] b;
  } vec_t;

  vec_t tbl[7];

  logic [31:0] opt[5];
  int stall_rem, flush_rem, m_stalls, m_flushes;

  initial begin
    clear_inputs();
    tbl[0] = '{5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, EX, 2'd0, DB};
    tbl[1] = '{5'd0, 5'd6, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, DA, 2'd0, DB};
    tbl[2] = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, AL, 2'd2, AL};
    tbl[3] = '{5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, DM, 2'd2, DM};
    tbl[4] = '{5'd9, 5'd9, 1'b1, 1'b0, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 2'd3, WB, 2'd0, DB};
    tbl[5] = '{5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, DA, 2'd0, DB};
    tbl[6] = '{5'd3, 5'd3, 1'b1, 1'b0, 5'd1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, AL, 2'd0, DB};
    opt[0] = 32'h0; opt[1] = 32'h1; opt[2] = 32'hFFFFFFFF; opt[3] = 32'h80000000; opt[4] = 32'h7FFFFFFF;

    // reset state
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    settle();
    check("reset_ctl", 128'(ctl()), 128'(35'd0));
    check("reset_state", 128'(dbg_state), 128'(RUN));
    check("reset_ctl4", 128'(ctl4()), 128'(35'd0));
    tick();

    for (int i = 0; i < 7; i++) begin
      de_rs1 = tbl[i].rs1; de_rs2 = tbl[i].rs2;
      de_rs1_used = tbl[i].u1; de_rs2_used = tbl[i].u2;
      exe_rd = tbl[i].erd; acc_rd = tbl[i].ard; wb_rd = tbl[i].wrd;
      exe_we = tbl[i].ewe; acc_we = tbl[i].awe; acc_is_load = tbl[i].ald; wb_we = tbl[i].wwe;
      settle();
      check($sformatf("fwd_vec%0d", i), 128'({fwd_sel_a, fwd_a, fwd_sel_b, fwd_b}),
            128'({tbl[i].sa, tbl[i].a, tbl[i].sb, tbl[i].b}));
      tick();
    end
    clear_inputs();
    tick();

    // load-use: two stall cycles with LOAD_LAT=2, one with LOAD_LAT=1
    de_rs2 = 5'd7; de_rs2_used = 1'b1; exe_rd = 5'd7; exe_we = 1'b1; exe_is_load = 1'b1;
    settle();
    check("lu_c0_stall", 128'(stall), 128'(1'b1));
    check("lu4_c0_stall", 128'(stall4), 128'(1'b1));
    tick();
    exe_we = 1'b0; exe_is_load = 1'b0; acc_rd = 5'd7; acc_we = 1'b1; acc_is_load = 1'b1;
    settle();
    check("lu_c1_stall", 128'(stall), 128'(1'b1));
    check("lu4_c1_stall", 128'(stall4), 128'(1'b0));
    check("lu_c1_fwd_b", 128'({fwd_sel_b, fwd_b}), 128'({2'd2, DM}));
    tick();
    settle();
    check("lu_c2_stall", 128'(stall), 128'(1'b0));
    clear_inputs();
    idle(2);

    // jump preempts an ongoing load-use stall
    de_rs1 = 5'd4; de_rs1_used = 1'b1; exe_rd = 5'd4; exe_we = 1'b1; exe_is_load = 1'b1;
    settle();
    check("pre_c0", 128'(ctl()), 128'({1'b1, 1'b0, 1'b0, 32'h0}));
    tick();
    clear_inputs();
    exe_is_jump = 1'b1; exe_target = 32'h2000;
    settle();
    check("pre_c1", 128'(ctl()), 128'({1'b0, 1'b1, 1'b1, 32'h2000}));
    tick();
    exe_is_jump = 1'b0;
    settle();
    check("pre_c2", 128'(ctl()), 128'({1'b0, 1'b1, 1'b0, 32'h0}));
    tick();
    settle();
    check("pre_c3", 128'(ctl()), 128'(35'd0));
    idle(5);

    // BLT taken on signed compare, BLTU of same operands not taken
    exe_is_branch = 1'b1; exe_funct3 = 3'b100; exe_op_a = 32'hFFFFFFFF; exe_op_b = 32'h1;
    exe_target = 32'h1000;
    settle();
    check("blt_c0", 128'(ctl()), 128'({1'b0, 1'b1, 1'b1, 32'h1000}));
    tick();
    exe_is_branch = 1'b0;
    settle();
    check("blt_c1", 128'(ctl()), 128'({1'b0, 1'b1, 1'b0, 32'h0}));
    tick();
    settle();
    check("blt_c2", 128'(ctl()), 128'(35'd0));
    idle(5);
    exe_is_branch = 1'b1; exe_funct3 = 3'b110;
    settle();
    check("bltu", 128'(ctl()), 128'(35'd0));
    clear_inputs();
    idle(2);

    // taken branch with load-use: redirect wins, inputs held through FLUSH
    de_rs1 = 5'd7; de_rs1_used = 1'b1; exe_rd = 5'd7; exe_we = 1'b1; exe_is_load = 1'b1;
    exe_is_branch = 1'b1; exe_funct3 = 3'b000; exe_op_a = 32'h5; exe_op_b = 32'h5;
    exe_target = 32'h3000;
    settle();
    check("tl_c0", 128'(ctl()), 128'({1'b0, 1'b1, 1'b1, 32'h3000}));
    tick();
    settle();
    check("tl_state", 128'(dbg_state), 128'(FLUSH));
    check("tl_c1", 128'(ctl()), 128'({1'b0, 1'b1, 1'b0, 32'h0}));
    clear_inputs();
    idle(6);

    // reset in the 2nd cycle of a 4-cycle flush
    exe_is_jump = 1'b1; exe_target = 32'h4000;
    settle();
    check("rf_c0", 128'(ctl4()), 128'({1'b0, 1'b1, 1'b1, 32'h4000}));
    tick();
    exe_is_jump = 1'b0;
    settle();
    check("rf_c1_flush", 128'(flush4), 128'(1'b1));
    rst = 1'b1;
    settle();
    check("rf_in_rst", 128'(ctl4()), 128'(35'd0));
    tick();
    rst = 1'b0;
    settle();
    check("rf_after", 128'(ctl4()), 128'(35'd0));
    check("rf_state", 128'(dbg_state4), 128'(RUN));

    // randomized cycles against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall_rem = 0; flush_rem = 0; m_stalls = 0; m_flushes = 0;
    for (int c = 0; c < 400; c++) begin
      logic lu, tk, e_st, e_fl, e_pc;
      logic [31:0] e_tg;
      de_rs1 = 5'($urandom_range(0, 3)); de_rs2 = 5'($urandom_range(0, 3));
      de_rs1_used = 1'($urandom_range(0, 1)); de_rs2_used = 1'($urandom_range(0, 1));
      de_data_a = $urandom; de_data_b = $urandom;
      exe_rd = 5'($urandom_range(0, 3)); acc_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      exe_we = 1'($urandom_range(0, 1)); acc_we = 1'($urandom_range(0, 1)); wb_we = 1'($urandom_range(0, 1));
      exe_is_load = ($urandom_range(0, 2) == 0); acc_is_load = 1'($urandom_range(0, 1));
      exe_result = $urandom; acc_alu = $urandom; acc_dmem = $urandom; wb_data = $urandom;
      exe_is_branch = ($urandom_range(0, 3) == 0); exe_is_jump = ($urandom_range(0, 9) == 0);
      exe_funct3 = 3'($urandom_range(0, 7));
      exe_op_a = opt[$urandom_range(0, 4)]; exe_op_b = opt[$urandom_range(0, 4)];
      exe_target = $urandom;
      settle();
      lu = exe_we && exe_is_load &&
           ((de_rs1_used && de_rs1 != 5'd0 && exe_rd == de_rs1) ||
            (de_rs2_used && de_rs2 != 5'd0 && exe_rd == de_rs2));
      tk = ref_taken();
      e_st = 1'b0; e_fl = 1'b0; e_pc = 1'b0; e_tg = 32'h0;
      if (flush_rem > 0) begin
        e_fl = 1'b1;
        flush_rem--;
      end else if (tk) begin
        e_fl = 1'b1; e_pc = 1'b1; e_tg = exe_target;
        flush_rem = FD - 1;
        stall_rem = 0;
      end else if (stall_rem > 0) begin
        e_st = 1'b1;
        stall_rem--;
      end else if (lu) begin
        e_st = 1'b1;
        stall_rem = LL - 1;
      end
      m_stalls += int'(e_st);
      m_flushes += int'(e_fl);
      exp_q.push_back({e_st, e_fl, e_pc, e_tg, ref_fwd(de_rs1_used, de_rs1, de_data_a),
                       ref_fwd(de_rs2_used, de_rs2, de_data_b)});
      check($sformatf("rand%0d", c),
            128'({stall, flush, pc_sel, pc_target, fwd_sel_a, fwd_a, fwd_sel_b, fwd_b}),
            128'(exp_q.pop_front()));
      tick();
    end
    clear_inputs();
    settle();
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall", 128'(perf_stall_cnt), 128'(32'(m_stalls)));
    check("perf_flush", 128'(perf_flush_cnt), 128'(32'(m_flushes)));
`endif

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
